// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and
// sizing constants common to imem_loader, byte_packer and instruction_memory.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int WORD_BYTES       = 4;
  localparam int IMEM_DEPTH_WORDS = 64;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: gathers four stream bytes little-endian into one 32-bit word and
// flags the handshake that completes the word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt;
  logic [31:0] acc;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= 2'd0;
      acc <= 32'd0;
    end else if (take) begin
      acc[{cnt, 3'b000} +: 8] <= byte_in;
      cnt                     <= cnt + 2'd1;
    end
  end

  // The completed word includes the byte arriving in this cycle, so the top can
  // capture it on the same edge that accepts the last byte.
  always_comb begin
    word                     = acc;
    word[{cnt, 3'b000} +: 8] = byte_in;
    word_full                = take && (cnt == 2'(WORD_BYTES - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit words and writes them to instruction
// memory. Optional macro IMEM_LOADER_CHECKSUM_EN adds an XOR checksum output.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter int                DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

  state_t           state, state_next;
  logic [IDX_W-1:0] word_idx;
  logic [15:0]      words_total;
  logic             start_acc;
  logic             too_big;
  logic             more;
  logic             take;
  logic [31:0]      packed_word;
  logic             word_full;

  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign too_big   = 32'(num_words) > 32'(DEPTH_WORDS);
  assign more      = (17'(word_idx) + 17'd1) < {1'b0, words_total};
  assign take      = byte_valid && byte_ready;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc),
    .take      (take),
    .byte_in   (byte_in),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = ((num_words == 16'd0) || too_big) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        byte_ready = !reset;
        busy       = 1'b1;
        if (word_full) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        wr_en      = !reset;
        busy       = 1'b1;
        state_next = more ? COLLECT : DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and data are latched as the last byte lands and then held, so the
  // write port stays stable outside the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      done        <= 1'b0;
      error       <= 1'b0;
      wr_addr     <= BASE_ADDR;
      wr_data     <= 32'd0;
      word_idx    <= '0;
      words_total <= 16'd0;
    end else begin
      if (start_acc) begin
        word_idx    <= '0;
        words_total <= num_words;
        done        <= (num_words == 16'd0) || too_big;
        error       <= too_big;
      end
      if ((state == COLLECT) && word_full) begin
        wr_data <= packed_word;
        wr_addr <= BASE_ADDR + (ADDR_W'(word_idx) << 2);
      end
      if (state == WRITE) begin
        word_idx <= word_idx + 1'b1;
        if (!more) begin
          done <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      checksum <= 32'd0;
    end else if (state == WRITE) begin
      checksum <= checksum ^ wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven randomized loads checked against
// a byte-list reference model, plus hand-written corner-case sequences.
module tb_imem_loader;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       num_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    int          mode;
    logic        expErr;
  } vec_t;

  wr_t        obsQ[$];
  logic [7:0] prog[$];
  vec_t       vecs[7];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .BASE_ADDR('0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Every write strobe seen by the memory side is logged for later comparison.
  always @(negedge clk) begin
    if (wr_en) obsQ.push_back('{wr_addr, wr_data});
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] n);
    @(negedge clk);
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start     = 1'b0;
  endtask

  function automatic logic [31:0] modelWord(input int i);
    return {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
  endfunction

  function automatic int modelWrites(input logic [15:0] n);
    return (int'(n) <= DEPTH) ? int'(n) : 0;
  endfunction

  // mode 0: always valid, 1: random valid, 2: valid toggles every cycle
  task automatic feedBytes(input int nBytes, input int mode, input bit midStart);
    int  idx = 0;
    int  cyc = 0;
    int  budget = 20 * nBytes + 50;
    bit  consumed;
    while (idx < nBytes && cyc < budget) begin
      byte_in = prog[idx];
      case (mode)
        1:       byte_valid = 1'($urandom_range(0, 1));
        2:       byte_valid = (cyc % 2 == 0);
        default: byte_valid = 1'b1;
      endcase
      if (midStart && cyc == 3) begin
        start     = 1'b1;
        num_words = 16'd5;
      end
      consumed = byte_valid && byte_ready;
      @(posedge clk);
      if (consumed) idx++;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (consumed && (idx % 4 == 0)) checkOutput("wr_en latency", wr_en, 1);
    end
    byte_valid = 1'b0;
    if (idx < nBytes) checkOutput("feed timeout", 0, 1);
  endtask

  task automatic waitDone();
    int c = 0;
    while (!done && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput("done", done, 1);
    @(negedge clk);
  endtask

  task automatic checkLoad(input logic [15:0] n, input logic expErr);
    int          nw = modelWrites(n);
    logic [31:0] x  = 32'd0;
    checkOutput("done flag", done, 1);
    checkOutput("error flag", error, expErr);
    checkOutput("busy after", busy, 0);
    checkOutput("write count", obsQ.size(), nw);
    for (int i = 0; i < nw && i < obsQ.size(); i++) begin
      checkOutput("write addr", obsQ[i].addr, 64'(4 * i));
      checkOutput("write data", obsQ[i].data, modelWord(i));
      x ^= modelWord(i);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("checksum", checksum, x);
`endif
  endtask

  task automatic randomProg(input int nBytes);
    prog.delete();
    for (int i = 0; i < nBytes; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    num_words  = 16'd0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset byte_ready", byte_ready, 0);
    checkOutput("reset wr_en", wr_en, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset error", error, 0);
    checkOutput("reset wr_addr", wr_addr, 0);
    checkOutput("reset wr_data", wr_data, 0);

    // Known two-instruction program.
    obsQ.delete();
    prog = '{8'h13, 8'h00, 8'h70, 8'h00, 8'h93, 8'h06, 8'hC0, 8'h0D};
    applyStimulus(16'd2);
    checkOutput("busy during", busy, 1);
    feedBytes(8, 0, 1'b0);
    waitDone();
    checkLoad(16'd2, 1'b0);
    if (obsQ.size() == 2) begin
      checkOutput("known word0", obsQ[0].data, 32'h00700013);
      checkOutput("known word1", obsQ[1].data, 32'h0DC00693);
    end else begin
      checkOutput("known count", obsQ.size(), 2);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("known checksum", checksum, 32'h0DB00680);
`endif

    // Table of randomized loads, including empty, full-depth and oversize counts.
    vecs[0] = '{16'd1,  0, 1'b0};
    vecs[1] = '{16'd3,  1, 1'b0};
    vecs[2] = '{16'd2,  2, 1'b0};
    vecs[3] = '{16'd0,  0, 1'b0};
    vecs[4] = '{16'd64, 1, 1'b0};
    vecs[5] = '{16'd65, 0, 1'b1};
    vecs[6] = '{16'd5,  1, 1'b0};
    for (int v = 0; v < 7; v++) begin
      obsQ.delete();
      randomProg(4 * modelWrites(vecs[v].n));
      applyStimulus(vecs[v].n);
      if (modelWrites(vecs[v].n) > 0) begin
        feedBytes(4 * modelWrites(vecs[v].n), vecs[v].mode, 1'b0);
      end else begin
        checkOutput("immediate done", done, 1);
        byte_valid = 1'b1;
        repeat (3) begin
          @(negedge clk);
          checkOutput("no byte_ready", byte_ready, 0);
        end
        byte_valid = 1'b0;
      end
      waitDone();
      checkLoad(vecs[v].n, vecs[v].expErr);
    end

    // After an oversize request, a valid start clears both sticky flags.
    obsQ.delete();
    applyStimulus(16'd65);
    checkOutput("oversize error", error, 1);
    randomProg(4);
    applyStimulus(16'd1);
    checkOutput("done cleared", done, 0);
    checkOutput("error cleared", error, 0);
    feedBytes(4, 2, 1'b0);
    waitDone();
    checkLoad(16'd1, 1'b0);

    // Reset in the middle of a word discards the partial bytes.
    obsQ.delete();
    randomProg(4);
    applyStimulus(16'd1);
    feedBytes(2, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset-cycle wr_en", wr_en, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset busy", busy, 0);
    checkOutput("post-reset done", done, 0);
    randomProg(4);
    applyStimulus(16'd1);
    feedBytes(4, 0, 1'b0);
    waitDone();
    checkLoad(16'd1, 1'b0);

    // Start pulsed while busy must not disturb the running load.
    obsQ.delete();
    randomProg(12);
    applyStimulus(16'd3);
    feedBytes(12, 0, 1'b1);
    waitDone();
    checkLoad(16'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
